// File: rtl/tmr_vote_sequencer_pkg.sv
// Package tmr_vote_pkg: shared types and constants for the TMR vote sequencer.
//   state_t     - sequencer FSM states (IDLE, COLLECT, VOTE, OUT)
//   NUM_CH      - number of redundant channels
//   CH0..CH2    - channel index constants
//   popcount3() - number of set bits in a 3-bit channel mask
package tmr_vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int NUM_CH = 3;
  localparam int CH0    = 0;
  localparam int CH1    = 1;
  localparam int CH2    = 2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/tmr_vote_sequencer_if.sv
// Interface tmr_vote_sequencer_if: groups the three producer channels and the
// consumer-side output handshake.
//   ch_valid/ch_data/ch_ready     - per-channel valid/ready, word i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data  - voted word handshake
//   out_agree                     - all three captured words were identical
// Modports: master = producers + consumer side, slave = the sequencer.
interface tmr_vote_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [2:0]          ch_valid;
  logic [3*DATA_W-1:0] ch_data;
  logic [2:0]          ch_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_agree;

  modport master (
    output ch_valid, ch_data, out_ready,
    input  ch_ready, out_valid, out_data, out_agree
  );

  modport slave (
    input  ch_valid, ch_data, out_ready,
    output ch_ready, out_valid, out_data, out_agree
  );
endinterface

// File: rtl/tmr_vote_sequencer_bit_vote.sv
// Module tmr_bit_vote: combinational bitwise 2-of-3 majority vote.
//   a, b, c    in   DATA_W  the three candidate words
//   vote       out  DATA_W  per-bit majority
//   all_equal  out  1       a == b == c
module tmr_bit_vote #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] vote,
  output logic              all_equal
);
  assign vote      = (a & b) | (b & c) | (c & a);
  assign all_equal = (a == b) && (b == c);
endmodule

// File: rtl/tmr_vote_sequencer.sv
// Module tmr_vote_sequencer: collects one word from each of three redundant
// channels, majority-votes them bitwise and presents the result downstream.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        tmr_vote_sequencer_if.slave (channel inputs, voted output)
//   vote_err   one-cycle pulse when a round is dropped for lack of a majority
//   ch_fault   sticky per-channel fault flags
//   clr_stats  synchronous clear of mismatch counters and ch_fault
// Optional feature macro: TMR_VOTE_STATS_EN enables per-channel saturating
// mismatch counters and fault flags; without it ch_fault is 000.
module tmr_vote_sequencer
  import tmr_vote_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 4,
  parameter int FAULT_THR = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tmr_vote_sequencer_if.slave   bus,
  output logic                  vote_err,
  output logic [NUM_CH-1:0]     ch_fault,
  input  logic                  clr_stats
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic                ready_en_reg;
  logic [NUM_CH-1:0]   got_reg;
  logic [DATA_W-1:0]   cap_reg [NUM_CH];
  logic [TMR_W-1:0]    timer_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic                out_agree_reg;
  logic                vote_err_reg;

  logic [NUM_CH-1:0]   ch_ready_c;
  logic [NUM_CH-1:0]   xfer;
  logic [1:0]          n_got;
  logic [1:0]          first_idx;
  logic [DATA_W-1:0]   eff [NUM_CH];
  logic [DATA_W-1:0]   maj;
  logic                all_eq;
  logic                vote_ok;

  assign xfer  = bus.ch_valid & ch_ready_c;
  assign n_got = popcount3(got_reg);

  // Missing channels are filled with a copy of a present word. With two words
  // present the majority is then the first present word, and all_eq reports
  // whether the two present words match; with three present nothing changes.
  assign first_idx = got_reg[CH0] ? 2'(CH0) : (got_reg[CH1] ? 2'(CH1) : 2'(CH2));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eff[gi] = got_reg[gi] ? cap_reg[gi] : cap_reg[first_idx];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cap_reg[gi] <= '0;
        else if (xfer[gi])
          cap_reg[gi] <= bus.ch_data[gi*DATA_W +: DATA_W];
      end
    end
  endgenerate

  tmr_bit_vote #(.DATA_W(DATA_W)) u_vote (
    .a         (eff[CH0]),
    .b         (eff[CH1]),
    .c         (eff[CH2]),
    .vote      (maj),
    .all_equal (all_eq)
  );

  assign vote_ok = (n_got == 2'd3) || ((n_got == 2'd2) && all_eq);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer == 3'b111)
          state_next = VOTE;
        else if (|xfer)
          state_next = COLLECT;
      end
      COLLECT: begin
        // A capture landing on the last timer cycle still joins this round.
        if (((got_reg | xfer) == 3'b111) || (timer_reg == '0))
          state_next = VOTE;
      end
      VOTE:    state_next = vote_ok ? OUT : IDLE;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. ready_en_reg keeps ch_ready low until the first clock after reset.
  always_comb begin
    ch_ready_c    = '0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE:    ch_ready_c    = {NUM_CH{ready_en_reg}};
      COLLECT: ch_ready_c    = ~got_reg;
      OUT:     bus.out_valid = 1'b1;
      default: ch_ready_c    = '0;
    endcase
  end

  assign bus.ch_ready  = ch_ready_c;
  assign bus.out_data  = out_data_reg;
  assign bus.out_agree = out_agree_reg;
  assign vote_err      = vote_err_reg;

  // Round bookkeeping, timeout timer and registered vote result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg  <= 1'b0;
      got_reg       <= '0;
      timer_reg     <= '0;
      out_data_reg  <= '0;
      out_agree_reg <= 1'b0;
      vote_err_reg  <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      got_reg      <= (state_next == IDLE) ? '0 : (got_reg | xfer);
      if (state_reg == COLLECT) begin
        if (timer_reg != '0)
          timer_reg <= timer_reg - 1'b1;
      end else begin
        timer_reg <= TMR_LOAD;
      end
      vote_err_reg <= (state_reg == VOTE) && !vote_ok;
      if ((state_reg == VOTE) && vote_ok) begin
        out_data_reg  <= maj;
        out_agree_reg <= (n_got == 2'd3) && all_eq;
      end
    end
  end

`ifdef TMR_VOTE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(FAULT_THR);

  logic [CNT_W-1:0] cnt_reg [NUM_CH];
  logic [NUM_CH-1:0] fault_reg;
  logic [NUM_CH-1:0] bump;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
      // A missing channel always counts; a present one only when it lost the vote.
      assign bump[gi] = (state_reg == VOTE) &&
                        (!got_reg[gi] || (vote_ok && (cap_reg[gi] != maj)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi]   <= '0;
          fault_reg[gi] <= 1'b0;
        end else if (clr_stats) begin
          cnt_reg[gi]   <= '0;
          fault_reg[gi] <= 1'b0;
        end else begin
          if (bump[gi] && (cnt_reg[gi] != CNT_MAX))
            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
          if (cnt_reg[gi] >= CNT_THR)
            fault_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign ch_fault = fault_reg;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign ch_fault = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_sequencer.sv
module tb_tmr_vote_sequencer;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

`ifdef TMR_VOTE_STATS_EN
  localparam logic [2:0] FAULT_EXP = 3'b100;
`else
  localparam logic [2:0] FAULT_EXP = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_stats;
  logic       vote_err;
  logic [2:0] ch_fault;

  tmr_vote_sequencer_if #(.DATA_W(DATA_W)) bus ();

  tmr_vote_sequencer #(
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(4), .FAULT_THR(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .vote_err  (vote_err),
    .ch_fault  (ch_fault),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents mask/data for one capture edge, then waits for out_valid or vote_err.
  // cyc counts clock edges from the start of the capture cycle.
  task automatic run_round(input logic [2:0] mask, input logic [7:0] d0, d1, d2,
                           output int cyc, output logic ov, output logic [7:0] od,
                           output logic oa, output logic err);
    ov = 1'b0; err = 1'b0; od = '0; oa = 1'b0; cyc = 0;
    bus.ch_valid = mask;
    bus.ch_data  = {d2, d1, d0};
    @(negedge clk);
    bus.ch_valid = 3'b000;
    cyc = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        ov = 1'b1; od = bus.out_data; oa = bus.out_agree;
        break;
      end
      if (vote_err) begin
        err = 1'b1;
        break;
      end
    end
    if (!ov && !err) check_eq("round_bound", 0, 1);
    $display("round mask=%b data=%h/%h/%h cyc=%0d out_valid=%b out_data=%h agree=%b vote_err=%b",
             mask, d0, d1, d2, cyc, ov, od, oa, err);
  endtask

  task automatic drain();
    @(negedge clk);
    check_eq("ov_drop", bus.out_valid, 1'b0);
  endtask

  int         cyc;
  logic       ov, oa, err, stable;
  logic [7:0] od;

  initial begin
    rst_n = 1'b0; clr_stats = 1'b0;
    bus.ch_valid = 3'b000; bus.ch_data = '0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check_eq("rst_ch_ready", bus.ch_ready, 3'b000);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_data", bus.out_data, 8'h00);
    check_eq("rst_out_agree", bus.out_agree, 1'b0);
    check_eq("rst_vote_err", vote_err, 1'b0);
    check_eq("rst_ch_fault", ch_fault, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", bus.ch_ready, 3'b111);

    // All agree
    run_round(3'b111, 8'hA5, 8'hA5, 8'hA5, cyc, ov, od, oa, err);
    check_eq("a5_cyc", cyc, 2);
    check_eq("a5_data", od, 8'hA5);
    check_eq("a5_agree", oa, 1'b1);
    drain();

    // ch2 disagrees, repeated until its fault flag trips
    for (int r = 0; r < 8; r++) begin
      if (r == 7) check_eq("fault_pre", ch_fault, 3'b000);
      run_round(3'b111, 8'h0F, 8'h0F, 8'hFF, cyc, ov, od, oa, err);
      check_eq("0f_data", od, 8'h0F);
      check_eq("0f_agree", oa, 1'b0);
      drain();
    end
    check_eq("fault_set", ch_fault, FAULT_EXP);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check_eq("fault_clr", ch_fault, 3'b000);
    run_round(3'b111, 8'h0F, 8'h0F, 8'hFF, cyc, ov, od, oa, err);
    drain();
    check_eq("fault_after_clr", ch_fault, 3'b000);

    // Three distinct words: F0/CC/AA -> E8
    run_round(3'b111, 8'hF0, 8'hCC, 8'hAA, cyc, ov, od, oa, err);
    check_eq("mix_data", od, 8'hE8);
    check_eq("mix_agree", oa, 1'b0);
    drain();

    // Partial round via timeout with two matching words
    run_round(3'b011, 8'h3C, 8'h3C, 8'h00, cyc, ov, od, oa, err);
    check_eq("part_cyc", cyc, TIMEOUT + 2);
    check_eq("part_ov", ov, 1'b1);
    check_eq("part_data", od, 8'h3C);
    check_eq("part_agree", oa, 1'b0);
    drain();

    // Two disagreeing words -> dropped round
    run_round(3'b011, 8'h11, 8'h22, 8'h00, cyc, ov, od, oa, err);
    check_eq("err2_pulse", err, 1'b1);
    check_eq("err2_cyc", cyc, TIMEOUT + 2);
    check_eq("err2_no_ov", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("err2_single", vote_err, 1'b0);
    check_eq("err2_idle", bus.ch_ready, 3'b111);

    // Single word -> dropped round
    run_round(3'b010, 8'h00, 8'h44, 8'h00, cyc, ov, od, oa, err);
    check_eq("err1_pulse", err, 1'b1);
    check_eq("err1_no_ov", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("err1_single", vote_err, 1'b0);

    // Staggered arrival: ch0 first, ch1/ch2 three cycles later
    bus.ch_valid = 3'b001; bus.ch_data = {8'h00, 8'h00, 8'hC3};
    @(negedge clk);
    bus.ch_valid = 3'b000;
    check_eq("collect_ready", bus.ch_ready, 3'b110);
    @(negedge clk); @(negedge clk);
    bus.ch_valid = 3'b110; bus.ch_data = {8'h81, 8'hC3, 8'h00};
    @(negedge clk);
    bus.ch_valid = 3'b000;
    check_eq("stag_vote_ov", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("stag_ov", bus.out_valid, 1'b1);
    check_eq("stag_data", bus.out_data, 8'hC3);
    check_eq("stag_agree", bus.out_agree, 1'b0);
    $display("round staggered out_data=%h agree=%b", bus.out_data, bus.out_agree);
    drain();

    // Backpressure: 10 stalled cycles in OUT with channels pushing
    bus.out_ready = 1'b0;
    run_round(3'b111, 8'hA5, 8'h5A, 8'hA5, cyc, ov, od, oa, err);
    check_eq("stall_data", od, 8'hA5);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ch_valid = 3'b111; bus.ch_data = 24'hFFFFFF;
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== 8'hA5 || bus.ch_ready !== 3'b000) stable = 1'b0;
    end
    check_eq("stall_stable", stable, 1'b1);
    bus.ch_valid = 3'b000;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of COLLECT
    bus.ch_valid = 3'b001; bus.ch_data = {8'h00, 8'h00, 8'h77};
    @(negedge clk);
    bus.ch_valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", bus.ch_ready, 3'b000);
    check_eq("mid_rst_ov", bus.out_valid, 1'b0);
    check_eq("mid_rst_data", bus.out_data, 8'h00);
    check_eq("mid_rst_fault", ch_fault, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_idle", bus.ch_ready, 3'b111);
    run_round(3'b111, 8'h5A, 8'h5A, 8'h5A, cyc, ov, od, oa, err);
    check_eq("after_rst_cyc", cyc, 2);
    check_eq("after_rst_data", od, 8'h5A);
    check_eq("after_rst_agree", oa, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
